debounce_bank: RTL and testbench

Multi-channel, parametrised input conditioner for front-panel buttons and switches. Each channel has a metastability synchroniser, an eager debouncer and a press-duration tracker. Each channel outputs a debounced level, one-cycle rise and fall pulses, a long-press pulse and an auto-repeat pulse. It sits between raw board pins and the UI/control logic, for example delay-adjust buttons that step repeatedly while held.

---
 rtl/debounce_bank.sv | 147 ++++++++++++++
 tb/tb_debounce_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel button/switch conditioner: synchroniser, eager debouncer with
// lockout, and press-duration tracker producing long-press and auto-repeat pulses.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int PERIOD        = 1000000,
  parameter int LONG_PERIOD   = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] signal_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int LOCK_W = $clog2(PERIOD);
  localparam int HOLD_W = $clog2(LONG_PERIOD + 1);
  localparam int REP_W  = (REPEAT_PERIOD > 2) ? $clog2(REPEAT_PERIOD) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PERIOD);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic              REP_EN    = (REPEAT_PERIOD > 0);

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync;
    state_t                 state_q;
    state_t                 state_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   long_q, long_d;
    logic                   rpt_q, rpt_d;
    logic [LOCK_W-1:0]      lock_q, lock_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [REP_W-1:0]       rep_q, rep_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], signal_in[i]};
    assign sync   = sync_q[SYNC_STAGES-1];

    // Debounce FSM and hold tracker next-state logic.
    always_comb begin
      state_d = state_q;
      level_d = level_q;
      lock_d  = lock_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      hold_d  = hold_q;
      rep_d   = rep_q;

      case (state_q)
        ST_READY: begin
          if (sync != level_q) begin
            level_d = sync;
            rise_d  = sync;
            fall_d  = ~sync;
            lock_d  = '0;
            state_d = ST_LOCKOUT;
          end else begin
            lock_d  = '0;
          end
        end
        ST_LOCKOUT: begin
          if (lock_q == LOCK_LAST) begin
            lock_d  = '0;
            state_d = ST_READY;
          end else begin
            lock_d  = lock_q + LOCK_W'(1);
          end
        end
        default: begin
          lock_d  = '0;
          state_d = ST_READY;
        end
      endcase

      // Keying off level_d lets a release on this edge suppress long/repeat.
      if (!level_d || rise_d) begin
        hold_d = '0;
        rep_d  = '0;
      end else if (hold_q == HOLD_LAST) begin
        hold_d = HOLD_MAX;
        rep_d  = '0;
        long_d = 1'b1;
      end else if (hold_q == HOLD_MAX) begin
        if (REP_EN && (rep_q == REP_LAST)) begin
          rep_d = '0;
          rpt_d = 1'b1;
        end else if (REP_EN) begin
          rep_d = rep_q + REP_W'(1);
        end else begin
          rep_d = '0;
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_q  <= '0;
        state_q <= ST_READY;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
        lock_q  <= '0;
        hold_q  <= '0;
        rep_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
        lock_q  <= lock_d;
        hold_q  <= hold_d;
        rep_q   <= rep_d;
      end
    end

    assign level_out[i]    = level_q;
    assign rise_pulse[i]   = rise_q;
    assign fall_pulse[i]   = fall_q;
    assign long_pulse[i]   = long_q;
    assign repeat_pulse[i] = rpt_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with small periods; pulses are logged per
// channel with their cycle index and compared with hand-derived timings.
module tb_debounce_bank;

  localparam int CH = 2;

  logic          clk;
  logic          resetn;
  logic [CH-1:0] sig;
  logic [CH-1:0] level_out, rise_pulse, fall_pulse, long_pulse, repeat_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;
  int c        = 0;
  int viol     = 0;
  int rise_cnt[CH], fall_cnt[CH], long_cnt[CH], rep_cnt[CH];
  int rise_cyc[CH], fall_cyc[CH], long_cyc[CH];
  int rep_cyc[CH][4];
  logic [CH-1:0] prev_rise, prev_fall, prev_long, prev_rep;
  logic [4:0]    pat;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(2), .PERIOD(4), .LONG_PERIOD(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .resetn(resetn), .signal_in(sig),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < CH; ch++) begin
      rise_cnt[ch] = 0; fall_cnt[ch] = 0; long_cnt[ch] = 0; rep_cnt[ch] = 0;
      rise_cyc[ch] = -1; fall_cyc[ch] = -1; long_cyc[ch] = -1;
      for (int k = 0; k < 4; k++) rep_cyc[ch][k] = -1;
    end
  endtask

  // One clock edge, then log pulses and check the per-cycle invariants.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < CH; ch++) begin
      if (rise_pulse[ch]) begin rise_cnt[ch]++; rise_cyc[ch] = cyc; end
      if (fall_pulse[ch]) begin fall_cnt[ch]++; fall_cyc[ch] = cyc; end
      if (long_pulse[ch]) begin long_cnt[ch]++; long_cyc[ch] = cyc; end
      if (repeat_pulse[ch]) begin
        if (rep_cnt[ch] < 4) rep_cyc[ch][rep_cnt[ch]] = cyc;
        rep_cnt[ch]++;
      end
    end
    if (((long_pulse | repeat_pulse) & ~level_out) != '0) viol++;
    if (((rise_pulse & prev_rise) | (fall_pulse & prev_fall) |
         (long_pulse & prev_long) | (repeat_pulse & prev_rep)) != '0) viol++;
    prev_rise = rise_pulse; prev_fall = fall_pulse;
    prev_long = long_pulse; prev_rep  = repeat_pulse;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; resetn = 1'b0; sig = 2'b11;
    prev_rise = '0; prev_fall = '0; prev_long = '0; prev_rep = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level_out, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    check("rst_long", long_pulse, 0);
    check("rst_repeat", repeat_pulse, 0);
    sig = 2'b00; resetn = 1'b1;
    repeat (5) step();
    check("idle_level", level_out, 0);

    // Clean press on ch0.
    clear_counts(); sig = 2'b01; base = cyc;
    step(); step(); step();
    check("t1_level", level_out, 2'b01);
    check("t1_rise", rise_pulse, 2'b01);
    check("t1_fall", fall_pulse, 0);
    step();
    check("t1_rise_width", rise_pulse, 0);
    repeat (6) step();
    sig = 2'b00;
    repeat (10) step();
    check("t1_fall_cnt", fall_cnt[0], 1);
    check("t1_fall_cyc", fall_cyc[0], base + 13);
    check("t1_no_long", long_cnt[0], 0);
    check("t1_ch1_quiet", rise_cnt[1] + fall_cnt[1] + long_cnt[1] + rep_cnt[1], 0);

    // Bounce ending low: trailing 0 accepted on the first READY edge.
    clear_counts(); pat = 5'b10101; base = cyc;
    for (int i = 0; i < 5; i++) begin sig[0] = pat[i]; step(); end
    sig[0] = 1'b0;
    repeat (7) step();
    check("t2b_rise_cnt", rise_cnt[0], 1);
    check("t2b_rise_cyc", rise_cyc[0], base + 3);
    check("t2b_fall_cnt", fall_cnt[0], 1);
    check("t2b_fall_cyc", fall_cyc[0], base + 8);
    check("t2b_level", level_out, 0);
    repeat (6) step();

    // Bounce ending high: a single rise, level stays 1.
    clear_counts(); base = cyc;
    for (int i = 0; i < 5; i++) begin sig[0] = pat[i]; step(); end
    sig[0] = 1'b1;
    repeat (7) step();
    check("t2a_rise_cnt", rise_cnt[0], 1);
    check("t2a_fall_cnt", fall_cnt[0], 0);
    check("t2a_level", level_out, 2'b01);
    sig[0] = 1'b0;
    repeat (8) step();
    check("t2a_fall_after", fall_cnt[0], 1);
    check("t2a_no_long", long_cnt[0], 0);
    repeat (6) step();

    // Long press with repeat on ch1; release lands on a would-be repeat edge.
    clear_counts(); sig[1] = 1'b1; base = cyc; c = base + 3;
    repeat (40) step();
    sig[1] = 1'b0;
    repeat (10) step();
    check("t3_rise_cyc", rise_cyc[1], c);
    check("t3_long_cnt", long_cnt[1], 1);
    check("t3_long_cyc", long_cyc[1], c + 20);
    check("t3_rep_cnt", rep_cnt[1], 3);
    check("t3_rep0", rep_cyc[1][0], c + 25);
    check("t3_rep1", rep_cyc[1][1], c + 30);
    check("t3_rep2", rep_cyc[1][2], c + 35);
    check("t3_fall_cnt", fall_cnt[1], 1);
    check("t3_fall_cyc", fall_cyc[1], c + 40);
    check("t3_ch0_quiet", rise_cnt[0], 0);
    repeat (6) step();

    // Release accepted exactly on the long-press edge suppresses long_pulse.
    clear_counts(); sig[0] = 1'b1; base = cyc; c = base + 3;
    repeat (20) step();
    sig[0] = 1'b0;
    repeat (8) step();
    check("t4_long_cnt", long_cnt[0], 0);
    check("t4_fall_cnt", fall_cnt[0], 1);
    check("t4_fall_cyc", fall_cyc[0], c + 20);
    repeat (6) step();

    // One cycle later the long press fires before the release.
    clear_counts(); sig[0] = 1'b1; base = cyc; c = base + 3;
    repeat (21) step();
    sig[0] = 1'b0;
    repeat (8) step();
    check("t4b_long_cyc", long_cyc[0], c + 20);
    check("t4b_fall_cyc", fall_cyc[0], c + 21);
    check("t4b_rep_cnt", rep_cnt[0], 0);
    repeat (6) step();

    // Concurrent rise, independent releases.
    clear_counts(); sig = 2'b11; base = cyc;
    repeat (5) step();
    sig[0] = 1'b0;
    repeat (5) step();
    check("t5_level_mid", level_out, 2'b10);
    sig[1] = 1'b0;
    repeat (8) step();
    check("t5_rise0", rise_cyc[0], base + 3);
    check("t5_rise1", rise_cyc[1], base + 3);
    check("t5_fall0", fall_cyc[0], base + 8);
    check("t5_fall1", fall_cyc[1], base + 13);
    repeat (6) step();

    // Reset mid-press, input held high throughout.
    sig[0] = 1'b1; base = cyc; c = base + 3;
    repeat (13) step();
    check("t6_level_pre", level_out, 2'b01);
    resetn = 1'b0;
    #1;
    check("t6_rst_outs", {level_out, rise_pulse, fall_pulse, long_pulse, repeat_pulse}, 0);
    step();
    resetn = 1'b1;
    clear_counts();
    repeat (30) step();
    check("t6_rise_cnt", rise_cnt[0], 1);
    check("t6_rise_cyc", rise_cyc[0], c + 14);
    check("t6_long_cyc", long_cyc[0], c + 34);
    sig[0] = 1'b0;
    repeat (8) step();
    check("t6_level_end", level_out, 0);

    check("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
